// File: rtl/prio_encoder_rr_pkg.sv
// prio_pkg: shared index-width helper and priority mode constants
package prio_pkg;
  localparam bit PRIO_FIXED = 1'b0;
  localparam bit PRIO_RR = 1'b1;
  function automatic int IDX_W(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prio_encoder_rr_if.sv
// prio_encoder_rr_if: request and result handshakes of the priority encoder
interface prio_encoder_rr_if #(parameter int N = 8);
  import prio_pkg::*;
  localparam int W = IDX_W(N);
  logic in_valid, in_ready, out_valid, out_ready, out_none, out_multi;
  logic [N-1:0] req;
  logic [W-1:0] out_idx;
  modport master(output in_valid, req, out_ready, input in_ready, out_valid, out_idx, out_none, out_multi);
  modport slave(input in_valid, req, out_ready, output in_ready, out_valid, out_idx, out_none, out_multi);
endinterface

// File: rtl/prio_encoder_rr_find.sv
// prio_find: combinational search of vec from start downward, wrapping at N-1
module prio_find #(parameter int N = 8, parameter int W = 3) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         none,
  output logic         multi
);
  logic [W-1:0] p;
  always_comb begin
    idx = '0;
    p = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = W'((int'(start) + N - k) % N);
      idx = vec[p] ? p : idx;
    end
  end
  assign none = ~|vec;
  assign multi = |(vec & (vec - N'(1)));
endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered N-to-log2(N) priority encoder, fixed or round-robin
module prio_encoder_rr #(parameter int N = 8, parameter int RR = 0) (
  input logic clk,
  input logic rst,
  prio_encoder_rr_if.slave bus
);
  import prio_pkg::*;
  localparam int W = IDX_W(N);
  logic [W-1:0] ptr, start, idx;
  logic none, multi, accept, take;
  assign start = (RR == int'(PRIO_RR)) ? ptr : W'(N - 1);
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign take = bus.out_valid && bus.out_ready;
  prio_find #(.N(N), .W(W)) u_find (.vec(bus.req), .start(start), .idx(idx), .none(none), .multi(multi));
  // an empty request leaves the pointer alone so the next winner is unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_idx <= '0;
      bus.out_none <= 1'b0;
      bus.out_multi <= 1'b0;
      ptr <= W'(N - 1);
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_idx <= idx;
      bus.out_none <= none;
      bus.out_multi <= multi;
      if (!none) ptr <= (idx == '0) ? W'(N - 1) : idx - W'(1);
    end else if (take) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: scoreboard bench for a fixed N=8 and a round-robin N=6 encoder
module tb_prio_encoder_rr;
  import prio_pkg::*;
  typedef struct { int idx; bit none; bit multi; } exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  prio_encoder_rr_if #(.N(8)) bus_f();
  prio_encoder_rr_if #(.N(6)) bus_r();
  prio_encoder_rr #(.N(8), .RR(int'(PRIO_FIXED))) dut_f (.clk(clk), .rst(rst), .bus(bus_f));
  prio_encoder_rr #(.N(6), .RR(int'(PRIO_RR))) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  exp_t q_f[$], q_r[$];
  exp_t ef, er;
  int ptr_r = 5;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  // round-robin reference: list indices in priority order, take the first requester
  function automatic exp_t rr_ref(input logic [7:0] r, input int n, input int start);
    exp_t e;
    int order[$];
    e.none = (r == 0);
    e.multi = $countones(r) >= 2;
    e.idx = 0;
    for (int k = start; k >= 0; k--) order.push_back(k);
    for (int k = n - 1; k > start; k--) order.push_back(k);
    for (int i = order.size() - 1; i >= 0; i--)
      if (((r >> order[i]) & 8'h01) != 0) e.idx = order[i];
    return e;
  endfunction

  task automatic push(input bit sel, input logic [7:0] r);
    exp_t e;
    if (sel) begin
      e = rr_ref(r & 8'h3F, 6, ptr_r);
      q_r.push_back(e);
      if (!e.none) ptr_r = (e.idx == 0) ? 5 : e.idx - 1;
    end else begin
      e.none = (r == 0);
      e.multi = $countones(r) >= 2;
      e.idx = e.none ? 0 : $clog2(int'(r) + 1) - 1;
      q_f.push_back(e);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input logic [7:0] r);
    if (sel) begin
      bus_r.in_valid = v;
      bus_r.req = r[5:0];
    end else begin
      bus_f.in_valid = v;
      bus_f.req = r;
    end
  endtask

  task automatic set_ready(input bit sel, input bit v);
    if (sel) bus_r.out_ready = v;
    else bus_f.out_ready = v;
  endtask

  function automatic bit in_rdy(input bit sel);
    return sel ? bus_r.in_ready : bus_f.in_ready;
  endfunction

  // called and returns at posedge+1; accepted at the edge after in_ready is seen
  task automatic send(input bit sel, input logic [7:0] r, input bit rnd);
    int n = 0;
    drive(sel, 1'b1, r);
    @(negedge clk);
    while (!in_rdy(sel) && n < 50) begin
      n++;
      @(posedge clk);
      #1;
      if (rnd) set_ready(sel, 1'b1);
      @(negedge clk);
    end
    if (n >= 50) chk("accept_timeout", 0, 1);
    else push(sel, r);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, r);
  endtask

  always @(negedge clk)
    if (!rst && bus_f.out_valid && bus_f.out_ready) begin
      if (q_f.size() == 0) chk("f_unexpected_out", 1, 0);
      else begin
        ef = q_f.pop_front();
        chk("f_idx", int'(bus_f.out_idx), ef.idx);
        chk("f_none", int'(bus_f.out_none), int'(ef.none));
        chk("f_multi", int'(bus_f.out_multi), int'(ef.multi));
      end
    end

  always @(negedge clk)
    if (!rst && bus_r.out_valid && bus_r.out_ready) begin
      if (q_r.size() == 0) chk("r_unexpected_out", 1, 0);
      else begin
        er = q_r.pop_front();
        chk("r_idx", int'(bus_r.out_idx), er.idx);
        chk("r_none", int'(bus_r.out_none), int'(er.none));
        chk("r_multi", int'(bus_r.out_multi), int'(er.multi));
      end
    end

  initial begin
    drive(0, 1'b1, 8'hFF);
    drive(1, 1'b1, 8'h3F);
    bus_f.out_ready = 1;
    bus_r.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_valid", int'(bus_f.out_valid), 0);
    chk("rst_f_ready", int'(bus_f.in_ready), 1);
    chk("rst_f_idx", int'(bus_f.out_idx), 0);
    chk("rst_f_none", int'(bus_f.out_none), 0);
    chk("rst_f_multi", int'(bus_f.out_multi), 0);
    chk("rst_r_valid", int'(bus_r.out_valid), 0);
    chk("rst_r_ready", int'(bus_r.in_ready), 1);
    chk("rst_r_idx", int'(bus_r.out_idx), 0);
    chk("rst_r_none", int'(bus_r.out_none), 0);
    chk("rst_r_multi", int'(bus_r.out_multi), 0);
    rst = 0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    send(0, 8'h80, 0);
    send(0, 8'h2C, 0);
    send(0, 8'h01, 0);
    send(0, 8'h00, 0);
    send(0, 8'h10, 0);
    bus_f.out_ready = 0;
    drive(0, 1'b1, 8'h02);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", int'(bus_f.in_ready), 0);
      chk("bp_out_valid", int'(bus_f.out_valid), 1);
      chk("bp_out_idx", int'(bus_f.out_idx), 4);
      @(posedge clk);
      #1;
    end
    bus_f.out_ready = 1;
    send(0, 8'h02, 0);
    send(1, 8'h3F, 0);
    send(1, 8'h00, 0);
    send(1, 8'h3F, 0);
    repeat (2) @(posedge clk);
    #1;
    bus_r.out_ready = 0;
    send(1, 8'h3F, 0);
    @(negedge clk);
    chk("midrst_valid_before", int'(bus_r.out_valid), 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    q_r.delete();
    q_f.delete();
    ptr_r = 5;
    @(negedge clk);
    chk("midrst_valid_after", int'(bus_r.out_valid), 0);
    @(posedge clk);
    #1;
    bus_r.out_ready = 1;
    repeat (8) send(1, 8'h3F, 0);
    send(1, 8'h06, 0);
    chk("rr_ptr_after_06", int'(dut_r.ptr), 1);
    for (int i = 0; i < 150; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      set_ready(0, $urandom_range(0, 3) != 0);
      send(0, r, 1);
      r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom) & 8'h3F;
      set_ready(1, $urandom_range(0, 3) != 0);
      send(1, r, 1);
    end
    bus_f.out_ready = 1;
    bus_r.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_f", q_f.size(), 0);
    chk("drain_r", q_r.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshakes on both sides. It accepts a request vector, resolves it to a single index, and holds that result in a one-entry output register until it is taken. A build-time mode selects fixed priority, where the highest index wins, or round-robin priority with a rotating pointer. It sits between request sources (interrupt lines, channel requests) and any consumer that needs one granted index per transfer.

## Interface
- `N`, 8, number of request lines; legal range 2..64; need not be a power of two.
- `W`, `$clog2(N)`, index width; derived, never overridden.
- `RR`, 0, 0 = fixed priority (highest index wins); 1 = round-robin.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `req` is presented.
- `in_ready`  out  1  block can accept `req` this cycle.
- `req`  in  N  request vector; bit i set means line i requests.
- `out_valid`  out  1  `out_idx`/`out_none`/`out_multi` are valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_idx`  out  W  granted index.
- `out_none`  out  1  accepted `req` was all-zero.
- `out_multi`  out  1  accepted `req` had two or more bits set.

## Operation
- Accept: `in_valid && in_ready`. Take: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational, so a take and an accept can happen in the same cycle.
- On accept, the output register loads the encoding of `req`, and `out_valid` is set to 1.
- On a take with no accept in the same cycle, `out_valid` is cleared to 0.
- Output fields hold their value while `out_valid` is high and `out_ready` is low.
- Fixed mode (`RR=0`):
  - Search order is N-1 down to 0.
  - `out_idx` is the first set bit found.
- Round-robin mode (`RR=1`):
  - Pointer `ptr` (W bits) holds the highest-priority index.
  - Search order is `ptr`, `ptr-1`, …, 0, N-1, …, `ptr+1`.
  - On an accept with `req != 0`: `ptr <= (out_idx == 0) ? N-1 : out_idx-1`.
  - Wrap is at N-1, not at 2^W-1.
- `req == 0` on accept:
  - `out_none=1`, `out_idx=0`, `out_multi=0`.
  - `ptr` is unchanged.
- `out_multi` is the popcount≥2 flag. It is independent of mode.
- In fixed mode, `ptr` is unused and may be removed by synthesis.
- `req` is sampled only on accept. Changes to `req` while `in_ready=0` are ignored.

## Timing
- Latency: result is visible one cycle after accept. Throughput is one result per cycle when `out_ready` is held high.
- Reset values (synchronous, take effect at the first edge with `rst=1`):
  - `out_valid=0`, `out_idx=0`, `out_none=0`, `out_multi=0`, `ptr=N-1`.
  - `in_ready` evaluates to 1 after reset.
  - The first round-robin result therefore matches fixed mode.
- Reset mid-transfer: a pending result is discarded with no take. `rst` has priority over accept and take in the same cycle.
- Simultaneous take + accept: `out_valid` stays 1, and the new result replaces the old one at the edge.
- Outputs change only on clock edges. The only combinational input-to-output path is `out_ready` → `in_ready`.

## Structure
- Shared package `prio_pkg`:
  - `IDX_W(n)` function (ceiling log2, minimum 1).
  - Mode constants `PRIO_FIXED=0` and `PRIO_RR=1`.
- Sub-module `prio_find` (purely combinational):
  - Ports: `vec[N]`, `start[W]` → `idx[W]`, `none`, `multi`.
  - Fixed mode instantiates it with `start=N-1`.
  - Round-robin mode passes `ptr`.
- Top level holds only the handshake logic, the output register and `ptr`.

## Test plan
- Reset: drive `rst=1` for 2 cycles with `in_valid=1`.
  - Required: `out_valid=0`, `in_ready=1`, all outputs 0.
  - Next accept with `req=8'h80` → `out_idx=7`.
- Fixed mode (N=8): send `req=8'b0010_1100` with `out_ready=1`.
  - Required one cycle later: `out_idx=5`, `out_multi=1`, `out_none=0`.
  - Then `req=8'h01` → `out_idx=0`, `out_multi=0`.
- Empty: send `req=0`.
  - Required: `out_none=1`, `out_idx=0`.
  - In RR mode, the following `req=8'hFF` still yields the index that `ptr` held before the empty request.
- Backpressure: accept `req=8'h10`, then hold `out_ready=0` for 3 cycles while offering `req=8'h02`.
  - Required: `in_ready=0`; `out_idx` stays 4 with `out_valid=1`.
  - Then raise `out_ready`: take and accept occur in the same cycle, and `out_idx=1` appears next.
- Round-robin (`RR=1`, N=6): 8 back-to-back accepts of `req=6'h3F`.
  - Required `out_idx` sequence: 5,4,3,2,1,0,5,4 (wrap at N-1, not at 7).
  - Then `req=6'b000110` with `ptr=3` → `out_idx=2`, then `ptr=1`.
- Reset mid-operation: assert `rst` while `out_valid=1` and `out_ready=0` in RR mode.
  - Required: `out_valid` cleared with no take.
  - `ptr` returns to N-1, so the next `req=all-ones` yields N-1.
